// File: rtl/mem_arb_pkg.sv
// Shared defaults and helpers for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_N    = 8;
    localparam int unsigned DEF_NREQ = 3;
    localparam int unsigned NREQ_MAX = 8;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic logic [2:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Rotating priority pick: first set bit of mask_i at or after start_i, wrapping.
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] mask_i,
    input  logic [IW-1:0]   start_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o,
    output logic [NREQ-1:0] oh_o
);

    logic [IW-1:0]       pos;
    logic                found;
    logic [NREQ_MAX-1:0] oh_pad;

    // Scan candidates in rotated order and keep the first hit.
    always_comb begin
        pos    = '0;
        found  = 1'b0;
        oh_o   = '0;
        oh_pad = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = IW'((32'(start_i) + k) % NREQ);
            if (!found && mask_i[pos]) begin
                found     = 1'b1;
                oh_o[pos] = 1'b1;
            end
        end
        oh_pad[NREQ-1:0] = oh_o;
        valid_o = found;
        idx_o   = IW'(onehot_to_idx(oh_pad));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter owning the 1W/2R data memory ports.
// Accept (gnt) -> access stage (memory ports from registers) -> response (rvalid/rdata).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned n    = DEF_N,
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*n-1:0] addr,
    input  logic [NREQ*n-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [NREQ*n-1:0] rdata,
    output logic              mem_wr_en,
    output logic [n-1:0]      mem_wr_addr,
    output logic [n-1:0]      mem_wr_data,
    output logic [n-1:0]      mem_rd0_addr,
    output logic [n-1:0]      mem_rd1_addr,
    input  logic [n-1:0]      mem_rd0_data,
    input  logic [n-1:0]      mem_rd1_data
);

    localparam int unsigned   IW   = $clog2(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    logic [NREQ-1:0][n-1:0] addr_a;
    logic [NREQ-1:0][n-1:0] wdata_a;

    assign addr_a  = addr;
    assign wdata_a = wdata;

    // Round-robin pointer
    logic [IW-1:0] ptr_q, ptr_d;

    // Access stage
    logic          wr_v_q, wr_v_d;
    logic [n-1:0]  wr_addr_q, wr_addr_d;
    logic [n-1:0]  wr_data_q, wr_data_d;
    logic          rd0_v_q, rd0_v_d;
    logic [IW-1:0] rd0_id_q, rd0_id_d;
    logic [n-1:0]  rd0_addr_q, rd0_addr_d;
    logic          rd1_v_q, rd1_v_d;
    logic [IW-1:0] rd1_id_q, rd1_id_d;
    logic [n-1:0]  rd1_addr_q, rd1_addr_d;

    // Response stage
    logic [NREQ-1:0]        rvalid_q, rvalid_d;
    logic [NREQ-1:0][n-1:0] rdata_q, rdata_d;

    // Winner selection
    logic            first_v, second_v;
    logic [IW-1:0]   first_idx, second_idx, second_start, last_idx;
    logic [NREQ-1:0] first_oh, second_oh, second_mask;
    logic            first_we, dual;

    mem_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_first (
        .mask_i  (req),
        .start_i (ptr_q),
        .valid_o (first_v),
        .idx_o   (first_idx),
        .oh_o    (first_oh)
    );

    mem_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_second (
        .mask_i  (second_mask),
        .start_i (second_start),
        .valid_o (second_v),
        .idx_o   (second_idx),
        .oh_o    (second_oh)
    );

    // Second search: pending reads only, starting just past the first winner.
    always_comb begin
        first_we     = |(we & first_oh);
        second_mask  = req & ~we & ~first_oh;
        second_start = (first_idx == LAST) ? '0 : first_idx + IW'(1);
        dual         = first_v && !first_we && second_v;
    end

    // Grants and pointer advance (past the last granted requester).
    always_comb begin
        gnt      = '0;
        ptr_d    = ptr_q;
        last_idx = dual ? second_idx : first_idx;
        if (rst_n && first_v) begin
            gnt = first_oh | (dual ? second_oh : '0);
        end
        if (first_v) begin
            ptr_d = (last_idx == LAST) ? '0 : last_idx + IW'(1);
        end
    end

    // Access-stage next state; addresses/data hold when their slot is idle.
    always_comb begin
        wr_v_d     = first_v && first_we;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd0_v_d    = first_v && !first_we;
        rd0_id_d   = rd0_id_q;
        rd0_addr_d = rd0_addr_q;
        rd1_v_d    = dual;
        rd1_id_d   = rd1_id_q;
        rd1_addr_d = rd1_addr_q;
        if (wr_v_d) begin
            wr_addr_d = addr_a[first_idx];
            wr_data_d = wdata_a[first_idx];
        end
        if (rd0_v_d) begin
            rd0_id_d   = first_idx;
            rd0_addr_d = addr_a[first_idx];
        end
        if (rd1_v_d) begin
            rd1_id_d   = second_idx;
            rd1_addr_d = addr_a[second_idx];
        end
    end

    // Response next state: route each read slot's data to its requester.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (rd0_v_q) begin
            rvalid_d[rd0_id_q] = 1'b1;
            rdata_d[rd0_id_q]  = mem_rd0_data;
        end
        if (rd1_v_q) begin
            rvalid_d[rd1_id_q] = 1'b1;
            rdata_d[rd1_id_q]  = mem_rd1_data;
        end
    end

    // All state; async reset discards any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            wr_v_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd0_v_q    <= 1'b0;
            rd0_id_q   <= '0;
            rd0_addr_q <= '0;
            rd1_v_q    <= 1'b0;
            rd1_id_q   <= '0;
            rd1_addr_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_v_q     <= wr_v_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd0_v_q    <= rd0_v_d;
            rd0_id_q   <= rd0_id_d;
            rd0_addr_q <= rd0_addr_d;
            rd1_v_q    <= rd1_v_d;
            rd1_id_q   <= rd1_id_d;
            rd1_addr_q <= rd1_addr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_wr_en    = wr_v_q;
    assign mem_wr_addr  = wr_addr_q;
    assign mem_wr_data  = wr_data_q;
    assign mem_rd0_addr = rd0_addr_q;
    assign mem_rd1_addr = rd1_addr_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x8 memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req, we, gnt, rvalid;
    logic [23:0] addr, wdata, rdata;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr, mem_wr_data, mem_rd0_addr, mem_rd1_addr;
    logic [7:0]  mem_rd0_data, mem_rd1_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.n(8), .NREQ(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd0_addr (mem_rd0_addr),
        .mem_rd1_addr (mem_rd1_addr),
        .mem_rd0_data (mem_rd0_data),
        .mem_rd1_data (mem_rd1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: one synchronous write port (plus bench preload), two async reads.
    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end
    assign mem_rd0_data = mem[mem_rd0_addr];
    assign mem_rd1_data = mem[mem_rd1_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic hold_reset;
        req = '0; we = '0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        req = '0; we = '0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        #2;
        req = 3'b111;
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
        n_cmp++; if (rdata !== 24'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 000000", rdata); end
        n_cmp++; if (mem_rd0_addr !== 8'h00) begin n_err++; $display("FAIL reset_rd0_addr: got %h expected 00", mem_rd0_addr); end
        tick(); tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt_held: got %b expected 000", gnt); end
        rst_n = 1'b1;
        we = 3'b111;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL reset_first_grant: got %b expected 001", gnt); end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_dual_read;
        hold_reset();
        preload(8'h10, 8'hA5);
        preload(8'h20, 8'h3C);
        rst_n = 1'b1;
        req = 3'b101; we = 3'b000; addr = {8'h20, 8'h00, 8'h10};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b101) begin n_err++; $display("FAIL dual_gnt: got %b expected 101", gnt); end
        tick();
        req = '0;
        @(negedge clk);
        n_cmp++; if (mem_rd0_addr !== 8'h10) begin n_err++; $display("FAIL dual_rd0_addr: got %h expected 10", mem_rd0_addr); end
        n_cmp++; if (mem_rd1_addr !== 8'h20) begin n_err++; $display("FAIL dual_rd1_addr: got %h expected 20", mem_rd1_addr); end
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL dual_rvalid_early: got %b expected 000", rvalid); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b101) begin n_err++; $display("FAIL dual_rvalid: got %b expected 101", rvalid); end
        n_cmp++; if (rdata[7:0] !== 8'hA5) begin n_err++; $display("FAIL dual_rdata0: got %h expected a5", rdata[7:0]); end
        n_cmp++; if (rdata[23:16] !== 8'h3C) begin n_err++; $display("FAIL dual_rdata2: got %h expected 3c", rdata[23:16]); end
        tick();
        // Pointer wrapped to 0: an all-write request picks requester 0.
        req = 3'b111; we = 3'b111; addr = {8'hF2, 8'hF1, 8'hF0};
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL dual_rvalid_pulse: got %b expected 000", rvalid); end
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL dual_ptr_wrap: got %b expected 001", gnt); end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_write_excl;
        hold_reset();
        rst_n = 1'b1;
        req = 3'b011; we = 3'b001; addr = {8'h00, 8'h41, 8'h40}; wdata = {8'h00, 8'h00, 8'h55};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL excl_gnt: got %b expected 001", gnt); end
        tick();
        req = 3'b010; we = 3'b000;
        @(negedge clk);
        n_cmp++; if (mem_wr_en !== 1'b1) begin n_err++; $display("FAIL excl_wr_en: got %b expected 1", mem_wr_en); end
        n_cmp++; if (mem_wr_addr !== 8'h40) begin n_err++; $display("FAIL excl_wr_addr: got %h expected 40", mem_wr_addr); end
        n_cmp++; if (mem_wr_data !== 8'h55) begin n_err++; $display("FAIL excl_wr_data: got %h expected 55", mem_wr_data); end
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL excl_gnt_next: got %b expected 010", gnt); end
        tick();
        req = '0;
        @(negedge clk);
        n_cmp++; if (mem[8'h40] !== 8'h55) begin n_err++; $display("FAIL excl_commit: got %h expected 55", mem[8'h40]); end
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL excl_wr_en_drop: got %b expected 0", mem_wr_en); end
        tick();
    endtask

    task automatic test_write_then_read;
        hold_reset();
        rst_n = 1'b1;
        req = 3'b001; we = 3'b001; addr = {8'h00, 8'h00, 8'h05}; wdata = {8'h00, 8'h00, 8'h77};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL wtr_wr_gnt: got %b expected 001", gnt); end
        tick();
        req = 3'b010; we = 3'b000; addr = {8'h00, 8'h05, 8'h00};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL wtr_rd_gnt: got %b expected 010", gnt); end
        tick();
        req = '0;
        @(negedge clk);
        n_cmp++; if (mem_rd0_addr !== 8'h05) begin n_err++; $display("FAIL wtr_rd_addr: got %h expected 05", mem_rd0_addr); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b010) begin n_err++; $display("FAIL wtr_rvalid: got %b expected 010", rvalid); end
        n_cmp++; if (rdata[15:8] !== 8'h77) begin n_err++; $display("FAIL wtr_rdata1: got %h expected 77", rdata[15:8]); end
        tick();
    endtask

    task automatic test_write_skip;
        hold_reset();
        preload(8'h60, 8'h5A);
        preload(8'h61, 8'hC3);
        rst_n = 1'b1;
        // Requester 1 has a pending write: the second read search must skip it.
        req = 3'b111; we = 3'b010; addr = {8'h61, 8'h99, 8'h60}; wdata = {8'h00, 8'hDD, 8'h00};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b101) begin n_err++; $display("FAIL skip_gnt: got %b expected 101", gnt); end
        tick();
        req = '0;
        @(negedge clk);
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL skip_wr_en: got %b expected 0", mem_wr_en); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b101) begin n_err++; $display("FAIL skip_rvalid: got %b expected 101", rvalid); end
        n_cmp++; if (rdata[7:0] !== 8'h5A) begin n_err++; $display("FAIL skip_rdata0: got %h expected 5a", rdata[7:0]); end
        n_cmp++; if (rdata[23:16] !== 8'hC3) begin n_err++; $display("FAIL skip_rdata2: got %h expected c3", rdata[23:16]); end
        tick();
    endtask

    task automatic test_same_addr;
        hold_reset();
        preload(8'h33, 8'h9E);
        rst_n = 1'b1;
        req = 3'b110; we = 3'b000; addr = {8'h33, 8'h33, 8'h00};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b110) begin n_err++; $display("FAIL same_gnt: got %b expected 110", gnt); end
        tick();
        req = '0;
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b110) begin n_err++; $display("FAIL same_rvalid: got %b expected 110", rvalid); end
        n_cmp++; if (rdata[15:8] !== 8'h9E) begin n_err++; $display("FAIL same_rdata1: got %h expected 9e", rdata[15:8]); end
        n_cmp++; if (rdata[23:16] !== 8'h9E) begin n_err++; $display("FAIL same_rdata2: got %h expected 9e", rdata[23:16]); end
        tick();
    endtask

    task automatic test_fairness;
        int cnt [3];
        logic [2:0] exp_g;
        hold_reset();
        rst_n = 1'b1;
        cnt = '{0, 0, 0};
        req = 3'b111; we = 3'b111; addr = {8'hB2, 8'hB1, 8'hB0}; wdata = {8'h03, 8'h02, 8'h01};
        for (int c = 0; c < 9; c++) begin
            exp_g = 3'b001 << (c % 3);
            @(negedge clk);
            n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL fair_gnt_c%0d: got %b expected %b", c, gnt, exp_g); end
            for (int i = 0; i < 3; i++) if (gnt[i]) cnt[i]++;
            tick();
        end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cnt[i] !== 3) begin n_err++; $display("FAIL fair_count%0d: got %0d expected 3", i, cnt[i]); end
        end
        tick();
    endtask

    task automatic test_async_reset;
        hold_reset();
        preload(8'h80, 8'h11);
        rst_n = 1'b1;
        req = 3'b001; we = 3'b001; addr = {8'h00, 8'h00, 8'h80}; wdata = {8'h00, 8'h00, 8'hEE};
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL areset_gnt: got %b expected 001", gnt); end
        tick();
        req = '0;
        #1;
        n_cmp++; if (mem_wr_en !== 1'b1) begin n_err++; $display("FAIL areset_wr_pending: got %b expected 1", mem_wr_en); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL areset_wr_drop: got %b expected 0", mem_wr_en); end
        tick();
        n_cmp++; if (mem[8'h80] !== 8'h11) begin n_err++; $display("FAIL areset_mem: got %h expected 11", mem[8'h80]); end
        // A read discarded by reset in its access cycle yields no response.
        rst_n = 1'b1;
        req = 3'b001; we = 3'b000;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL areset_rd_gnt: got %b expected 001", gnt); end
        tick();
        req = '0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL areset_rvalid: got %b expected 000", rvalid); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dual_read();
        test_write_excl();
        test_write_then_read();
        test_write_skip();
        test_same_addr();
        test_fairness();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the 256-entry, 8-bit, one-write/two-async-read data memory among NREQ requesters (instruction fetch, load/store unit, DMA/debug) of the multi-cycle processor. It sits between the requesters and the memory and owns all memory port signals. Each cycle it grants either one write or up to two reads. It registers the access into a one-cycle memory stage and returns read data one cycle later.

## Interface
Parameters:
- n, 8, data and address width
- NREQ, 3, number of requesters (2..8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; held with we/addr/wdata stable until granted
- we  in  NREQ  1 = write, 0 = read
- addr  in  NREQ*n  packed addresses; requester i at bits [i*n +: n]
- wdata  in  NREQ*n  packed write data
- gnt  out  NREQ  combinational accept, same cycle as req
- rvalid  out  NREQ  registered; read data for requester i valid this cycle
- rdata  out  NREQ*n  registered per-requester read data
- mem_wr_en  out  1  to memory wr_en
- mem_wr_addr  out  n  to memory wr_addr
- mem_wr_data  out  n  to memory wr_data
- mem_rd0_addr, mem_rd1_addr  out  n each  to memory read addresses
- mem_rd0_data, mem_rd1_data  in  n each  asynchronous read data from memory

## Operation
- Pipeline: accept (cycle T, gnt) -> access (T+1, memory ports driven from registers) -> response (T+2, rvalid/rdata).
- Round-robin pointer ptr (log2 NREQ bits, reset 0). The first winner is the first requester with req=1, searching from ptr upward and wrapping.
- First winner is a write: only that requester is granted. It occupies the write port in T+1.
- First winner is a read: a second winner is the next requester with req=1 and we=0, searching from first+1 and wrapping, excluding the first winner. Pending writes are skipped for this search. The first winner uses rd0 and the second uses rd1.
- ptr <= (last granted index + 1) mod NREQ. The last granted index is the second winner if one exists, otherwise the first. ptr is unchanged when nothing is granted.
- Access stage registers: wr_v, wr_addr, wr_data, rd0_v, rd0_id, rd0_addr, rd1_v, rd1_id, rd1_addr.
- mem_wr_en = wr_v. When idle, read addresses hold their last value (don't-care).
- Response: at the end of T+1, mem_rdK_data is captured into rdata[rdK_id]. rvalid[rdK_id] is set for exactly one cycle (T+2).
- Both reads may target the same address. Each gets the correct data.
- No stall input: gnt depends only on req, we, and ptr. The arbiter accepts every cycle.

## Timing
- Reset (async, rst_n=0): ptr=0. All access-stage valids=0, so mem_wr_en=0 immediately. rvalid=0, rdata=0, mem_*_addr=0, mem_wr_data=0. gnt is forced to 0 while rst_n=0.
- Reset mid-operation: in-flight accesses are discarded. A registered write is never committed once rst_n falls. No rvalid appears for discarded reads.
- Read latency: req high in T -> gnt in T -> rvalid/rdata in T+2.
- Write: commits at the rising edge ending T+1.
- Throughput: 1 write or 2 reads per cycle.
- Write granted in T, read of the same address granted in T+1: the read returns the new data, because the write commits before the read's access cycle.
- Read and write to the same address in flight together: impossible, since the two are never granted in the same cycle.
- A requester must drop req (or change the request) in the cycle after gnt. A held req is treated as a new request.

## Structure
- Package mem_arb_pkg: default N and NREQ, and the function onehot_to_idx.
- Sub-module mem_rr_pick: combinational, instantiated twice. Inputs: a mask vector and a start index. Outputs: a valid flag and a winner index. Instance 1 masks with req. Instance 2 masks with req & ~we & ~(first-winner one-hot) and starts at first+1.
- Top level holds ptr, the access-stage registers, and the response registers.

## Test plan
- Reset: hold rst_n=0 while req=3'b111 -> gnt=0, mem_wr_en=0, rvalid=0. Release -> ptr=0, and the first grant goes to requester 0.
- Dual read: ptr=0; req0 reads 0x10 (mem=0xA5) and req2 reads 0x20 (mem=0x3C); req1 idle -> gnt=3'b101 in T. rvalid=3'b101 in T+2, rdata0=0xA5, rdata2=0x3C. ptr becomes 0 (wrapped from 2+1).
- Write exclusivity: ptr=0; req0 writes 0x55 to 0x40 and req1 reads -> only gnt0. mem_wr_en=1 with addr 0x40 in T+1. req1 is granted in T+1.
- Write-then-read: req0 writes 0x77 to 0x05 in T; req1 reads 0x05 in T+1 -> rdata1=0x77 at T+3.
- Fairness: all three requesters hold write requests continuously for 9 cycles -> grant order 0,1,2,0,1,2,... with 3 grants each.
- Async reset mid-write: assert rst_n=0 during T+1 of a write to 0x80 -> mem_wr_en drops immediately, and mem[0x80] is unchanged.
